// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared aluop encodings, selector constants and FSM state type for the sliced ALU
package alu_pkg;

    // Full 3-bit aluop values: bit2 inverts B and forces carry-in, bits[1:0] select the output
    localparam logic [2:0] ALUOP_AND = 3'b000;
    localparam logic [2:0] ALUOP_OR  = 3'b001;
    localparam logic [2:0] ALUOP_ADD = 3'b010;
    localparam logic [2:0] ALUOP_SUB = 3'b110;
    localparam logic [2:0] ALUOP_SLT = 3'b111;

    // Output selector, aluop[1:0]
    localparam logic [1:0] SEL_AND  = 2'b00;
    localparam logic [1:0] SEL_OR   = 2'b01;
    localparam logic [1:0] SEL_SUM  = 2'b10;
    localparam logic [1:0] SEL_LESS = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/alu_slice.sv
// rtl/alu_slice.sv - combinational SLICE-bit group of ALU bit cells with ripple carry
//
// Ports:
//   a, b     : SLICE-bit operand slices (b is raw; inversion applied here from aluop[2])
//   cin      : carry into bit 0 of the slice
//   aluop    : 3-bit operation code
//   out      : selected per-bit value (AND/OR/SUM; LESS yields 0, the top patches bit 0)
//   cout     : carry out of the slice top bit
//   msb_cin  : carry into the slice top bit, used for signed overflow
//   sum_msb  : sum bit of the slice top bit
import alu_pkg::*;

module alu_slice #(
    parameter int SLICE = 8
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin,
    input  logic [2:0]       aluop,
    output logic [SLICE-1:0] out,
    output logic             cout,
    output logic             msb_cin,
    output logic             sum_msb
);

    logic [SLICE-1:0] b_eff;
    logic [SLICE-1:0] sum;
    logic [SLICE:0]   c;

    always_comb begin
        b_eff = b ^ {SLICE{aluop[2]}};
        c     = '0;
        sum   = '0;
        c[0]  = cin;
        for (int i = 0; i < SLICE; i++) begin
            sum[i]  = a[i] ^ b_eff[i] ^ c[i];
            c[i+1]  = (a[i] & b_eff[i]) | (a[i] & c[i]) | (b_eff[i] & c[i]);
        end
        cout    = c[SLICE];
        msb_cin = c[SLICE-1];
        sum_msb = sum[SLICE-1];
    end

    always_comb begin
        out = '0;
        case (aluop[1:0])
            SEL_AND:  out = a & b_eff;
            SEL_OR:   out = a | b_eff;
            SEL_SUM:  out = sum;
            default:  out = '0;
        endcase
    end

endmodule

// File: rtl/sliced_alu.sv
// rtl/sliced_alu.sv - multi-cycle WIDTH-bit ALU evaluating SLICE bits per clock behind valid/ready
//
// Ports:
//   clk, rst_n           : rising-edge clock, asynchronous active-low reset
//   in_valid, in_ready   : operation request handshake (a, b, aluop)
//   a, b                 : WIDTH-bit operands
//   aluop                : bit2 invert B / carry-in 1; bits[1:0] AND, OR, SUM, LESS
//   out_valid, out_ready : result handshake
//   result               : WIDTH-bit result
//   zero, carry, overflow: flags of the result (carry/overflow only for SUM/LESS)
import alu_pkg::*;

module sliced_alu #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       aluop,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             overflow
);

    localparam int NSLICES = WIDTH / SLICE;
    localparam int CNT_W   = (NSLICES > 1) ? $clog2(NSLICES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NSLICES - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [2:0]       op_q, op_d;
    logic             carry_reg_q, carry_reg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             carry_flag_q, carry_flag_d;
    logic             ovf_q, ovf_d;

    logic [SLICE-1:0] a_sl, b_sl, sl_out;
    logic             sl_cout, sl_msb_cin, sl_sum_msb;
    logic             ovf_now;
    int               base;

    always_comb begin
        base = int'(cnt_q) * SLICE;
        a_sl = a_q[base +: SLICE];
        b_sl = b_q[base +: SLICE];
    end

    alu_slice #(.SLICE(SLICE)) u_slice (
        .a       (a_sl),
        .b       (b_sl),
        .cin     (carry_reg_q),
        .aluop   (op_q),
        .out     (sl_out),
        .cout    (sl_cout),
        .msb_cin (sl_msb_cin),
        .sum_msb (sl_sum_msb)
    );

    // Only meaningful on the last slice, where the slice top bit is the word MSB
    assign ovf_now = sl_msb_cin ^ sl_cout;

    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        op_d         = op_q;
        carry_reg_d  = carry_reg_q;
        cnt_d        = cnt_q;
        result_d     = result_q;
        zero_d       = zero_q;
        carry_flag_d = carry_flag_q;
        ovf_d        = ovf_q;
        in_ready     = 1'b0;
        out_valid    = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
            end
            RUN: begin
                result_d[base +: SLICE] = sl_out;
                carry_reg_d             = sl_cout;
                cnt_d                   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    // LESS slices all wrote 0; bit 0 gets the signed compare outcome
                    if (op_q[1:0] == SEL_LESS) begin
                        result_d[0] = sl_sum_msb ^ ovf_now;
                    end
                    zero_d       = (result_d == '0);
                    carry_flag_d = op_q[1] & sl_cout;
                    ovf_d        = op_q[1] & ovf_now;
                    cnt_d        = '0;
                    state_d      = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Accept covers both IDLE and the no-bubble handoff out of DONE
        if (in_ready && in_valid) begin
            a_d         = a;
            b_d         = b;
            op_d        = aluop;
            carry_reg_d = aluop[2];
            cnt_d       = '0;
            state_d     = RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= '0;
            carry_reg_q  <= 1'b0;
            cnt_q        <= '0;
            result_q     <= '0;
            zero_q       <= 1'b0;
            carry_flag_q <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            op_q         <= op_d;
            carry_reg_q  <= carry_reg_d;
            cnt_q        <= cnt_d;
            result_q     <= result_d;
            zero_q       <= zero_d;
            carry_flag_q <= carry_flag_d;
            ovf_q        <= ovf_d;
        end
    end

    assign result   = result_q;
    assign zero     = zero_q;
    assign carry    = carry_flag_q;
    assign overflow = ovf_q;

endmodule
